axi_stream_1_to_2_demux: RTL
============================

Name: axi_stream_1_to_2_demux

Overview:
Packet-granular AXI Stream demultiplexer, 1 input to 2 outputs. It is the receive-side counterpart of the 2-to-1 arbiter: the arbiter prepends the selected stream number as the TID MSB, and this block routes on that bit and strips it. Routing is decided on the first beat of a packet and held until tlast. It sits between a shared stream and two per-stream consumers.

Parameters:
AXIS_BUS_WIDTH, 64, tdata width; tkeep is AXIS_BUS_WIDTH/8.
AXIS_OUT_TID_WIDTH, 1, output tid width (min 1).
AXIS_TDEST_WIDTH, 1, tdest width.
AXIS_TUSER_WIDTH, 1, tuser width.
AXIS_IN_TID_WIDTH, AXIS_OUT_TID_WIDTH+1, derived; do not override.

Ports:
aclk  in  1  clock; all interfaces synchronous to it.
aresetn  in  1  reset, asynchronous assert, active-low.
axis_in_tdata/tkeep/tid/tdest/tuser/tlast  in  per params  input stream payload.
axis_in_tvalid  in  1  input valid.
axis_in_tready  out  1  input ready; registered.
axis_out_0_tdata/tkeep/tid/tdest/tuser/tlast  out  per params  output 0 payload; tid is AXIS_OUT_TID_WIDTH.
axis_out_0_tvalid  out  1  output 0 valid.
axis_out_0_tready  in  1  output 0 ready.
axis_out_1_*  same as output 0, for output 1.
route_err  out  1  sticky; TID MSB changed mid-packet.

Behaviour:
- Reset (async, aresetn=0):
  - all out tvalid=0, all payload=0.
  - axis_in_tready=0; it rises on the first aclk edge after release.
  - Routing state = IDLE; route_sel=0; route_err=0.
  - Reset mid-packet discards buffered beats and the in-progress packet.
- Input stage is a 2-entry skid buffer (main + skid):
  - axis_in_tready = !skid_valid, registered.
  - Accept when axis_in_tvalid && axis_in_tready.
  - Sustains 1 beat/clk when the chosen output is always ready.
  - The head beat is the main register. An accepted beat never drops or duplicates.
- Latency: 1 clk from input accept to head visible at the output, when the buffer was empty.
- Routing FSM:
  - IDLE: sel = head.tid[MSB].
    - If head valid and accepted with tlast=0: route_sel<=sel, go to BUSY.
    - If accepted with tlast=1: stay in IDLE (single-beat packet).
  - BUSY: sel = route_sel; the head tid MSB is ignored for routing.
    - An accepted beat with tlast=1 returns to IDLE.
    - An accepted beat whose tid MSB != route_sel sets route_err=1. It stays set until reset, and the beat is still routed to route_sel.
- Outputs:
  - axis_out_N_tvalid = head_valid && (sel==N).
  - Non-selected output tvalid=0; its payload mirrors the head and is don't-care.
  - axis_out_N_tid = head.tid[AXIS_OUT_TID_WIDTH-1:0]; the MSB is stripped.
  - tdata/tkeep/tdest/tuser/tlast pass through unchanged.
  - Head consumed when axis_out_sel_tready && head_valid.
  - The non-selected output's tready is ignored.
- Head-of-line: a stalled selected output blocks the input; the other output is idle. This is intended.
- AXI rule: once tvalid is asserted, payload and tvalid hold stable until the handshake. Routing cannot change while the head is pending, because sel derives only from FSM state and head contents.
- Simultaneous input accept and output consume with skid empty: main reloads directly; skid stays empty.

Decomposition:
- Shared package axis_pkg: localparam functions for tkeep width and the derived TID width.
- The same package holds typedef enum {IDLE, BUSY} demux_state_t for reuse by an N-way variant.
- One natural sub-module: axis_skid_buffer, a parameterized-payload 2-entry register slice with registered tready. It is reusable by the arbiter's input stage.
- FSM and output muxing stay in the top.

Test Plan:
- Reset release: aresetn low→high. axis_in_tready=0 at release and 1 one edge later; all tvalid=0, route_err=0.
- Routing: 3-beat packet, tid=2'b10, data 0xA0..0xA2, tlast on the 3rd beat → all on out_1 with tid=1'b0, data in order; out_0_tvalid never asserted.
- Back-to-back:
  - Stimulus: pkt tid=2'b01 (2 beats) then tid=2'b11 (1 beat), input valid every clk, both readies=1.
  - Required: out_0 gets 2 beats, out_1 gets 1 beat, no bubble; axis_in_tready stays 1 throughout.
- Backpressure:
  - Stimulus: 4-beat pkt to out_0, out_0_tready=0 for 5 clk.
  - Required: axis_in_tready drops after 2 beats are buffered; release delivers all 4 beats exactly once, in order; out_1_tready toggling has no effect.
- Mid-packet TID change:
  - Stimulus: beats with tid MSB 0,1,0, tlast on the 3rd.
  - Required: all 3 beats on out_0; route_err=1 from the clk after beat 2, stays 1.
- Async reset mid-packet:
  - Stimulus: aresetn low between beats 1 and 2 of a packet to out_1.
  - Required: all tvalid=0 immediately, without waiting for a clock edge; after release, a new packet with tid=2'b00 routes to out_0.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared AXI Stream helpers: derived sideband widths and routing state type
// used by the stream demux family.
package axis_pkg;

  typedef enum logic [0:0] {
    IDLE,
    BUSY
  } demux_state_t;

  function automatic int unsigned tkeep_width(input int unsigned bus_width);
    return bus_width / 8;
  endfunction

  // Input TID carries one extra MSB holding the source stream number.
  function automatic int unsigned in_tid_width(input int unsigned out_tid_width);
    return out_tid_width + 1;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry register slice (main + skid) with a registered in_ready;
// the main register is always the head presented downstream.
module axis_skid_buffer #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
);

  logic                  main_valid, main_valid_n;
  logic                  skid_valid, skid_valid_n;
  logic [DATA_WIDTH-1:0] main_data, main_data_n;
  logic [DATA_WIDTH-1:0] skid_data, skid_data_n;
  logic                  accept, consume;

  assign accept    = in_valid && in_ready;
  assign consume   = out_ready && main_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  // Consume first so a simultaneous accept can refill main directly.
  always_comb begin
    main_valid_n = main_valid;
    main_data_n  = main_data;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    if (consume) begin
      if (skid_valid) begin
        main_valid_n = 1'b1;
        main_data_n  = skid_data;
      end else begin
        main_valid_n = 1'b0;
      end
      skid_valid_n = 1'b0;
    end
    if (accept) begin
      if (!main_valid_n) begin
        main_valid_n = 1'b1;
        main_data_n  = in_data;
      end else begin
        skid_valid_n = 1'b1;
        skid_data_n  = in_data;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
      in_ready   <= 1'b0;
    end else begin
      main_valid <= main_valid_n;
      skid_valid <= skid_valid_n;
      main_data  <= main_data_n;
      skid_data  <= skid_data_n;
      in_ready   <= !skid_valid_n;
    end
  end

endmodule

// File: rtl/axi_stream_1_to_2_demux.sv
// Packet-granular 1-to-2 AXI Stream demux: routes on the input TID MSB latched
// at the first beat of a packet, strips that bit, flags mid-packet changes.
module axi_stream_1_to_2_demux
  import axis_pkg::*;
#(
  parameter  int unsigned AXIS_BUS_WIDTH     = 64,
  parameter  int unsigned AXIS_OUT_TID_WIDTH = 1,
  parameter  int unsigned AXIS_TDEST_WIDTH   = 1,
  parameter  int unsigned AXIS_TUSER_WIDTH   = 1,
  localparam int unsigned AXIS_IN_TID_WIDTH  = in_tid_width(AXIS_OUT_TID_WIDTH),
  localparam int unsigned AXIS_KEEP_WIDTH    = tkeep_width(AXIS_BUS_WIDTH)
) (
  input  logic                          aclk,
  input  logic                          aresetn,

  input  logic [AXIS_BUS_WIDTH-1:0]     axis_in_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]    axis_in_tkeep,
  input  logic [AXIS_IN_TID_WIDTH-1:0]  axis_in_tid,
  input  logic [AXIS_TDEST_WIDTH-1:0]   axis_in_tdest,
  input  logic [AXIS_TUSER_WIDTH-1:0]   axis_in_tuser,
  input  logic                          axis_in_tlast,
  input  logic                          axis_in_tvalid,
  output logic                          axis_in_tready,

  output logic [AXIS_BUS_WIDTH-1:0]     axis_out_0_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]    axis_out_0_tkeep,
  output logic [AXIS_OUT_TID_WIDTH-1:0] axis_out_0_tid,
  output logic [AXIS_TDEST_WIDTH-1:0]   axis_out_0_tdest,
  output logic [AXIS_TUSER_WIDTH-1:0]   axis_out_0_tuser,
  output logic                          axis_out_0_tlast,
  output logic                          axis_out_0_tvalid,
  input  logic                          axis_out_0_tready,

  output logic [AXIS_BUS_WIDTH-1:0]     axis_out_1_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]    axis_out_1_tkeep,
  output logic [AXIS_OUT_TID_WIDTH-1:0] axis_out_1_tid,
  output logic [AXIS_TDEST_WIDTH-1:0]   axis_out_1_tdest,
  output logic [AXIS_TUSER_WIDTH-1:0]   axis_out_1_tuser,
  output logic                          axis_out_1_tlast,
  output logic                          axis_out_1_tvalid,
  input  logic                          axis_out_1_tready,

  output logic                          route_err
);

  localparam int unsigned PAYLOAD_WIDTH = AXIS_BUS_WIDTH + AXIS_KEEP_WIDTH +
      AXIS_IN_TID_WIDTH + AXIS_TDEST_WIDTH + AXIS_TUSER_WIDTH + 1;

  logic [PAYLOAD_WIDTH-1:0]      in_payload, head_payload;
  logic                          head_valid, head_ready;
  logic [AXIS_BUS_WIDTH-1:0]     head_tdata;
  logic [AXIS_KEEP_WIDTH-1:0]    head_tkeep;
  logic [AXIS_IN_TID_WIDTH-1:0]  head_tid;
  logic [AXIS_TDEST_WIDTH-1:0]   head_tdest;
  logic [AXIS_TUSER_WIDTH-1:0]   head_tuser;
  logic                          head_tlast;
  logic                          head_msb;

  demux_state_t state, state_n;
  logic         route_sel, route_sel_n;
  logic         route_err_n;
  logic         sel, consume;

  assign in_payload = {axis_in_tdata, axis_in_tkeep, axis_in_tid,
                       axis_in_tdest, axis_in_tuser, axis_in_tlast};
  assign {head_tdata, head_tkeep, head_tid,
          head_tdest, head_tuser, head_tlast} = head_payload;
  assign head_msb = head_tid[AXIS_IN_TID_WIDTH-1];

  axis_skid_buffer #(
    .DATA_WIDTH (PAYLOAD_WIDTH)
  ) u_skid (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .in_valid  (axis_in_tvalid),
    .in_ready  (axis_in_tready),
    .in_data   (in_payload),
    .out_valid (head_valid),
    .out_data  (head_payload),
    .out_ready (head_ready)
  );

  // sel depends only on FSM state and head contents, so it is stable while
  // the head is pending and the non-selected tready never matters.
  always_comb begin
    sel         = (state == BUSY) ? route_sel : head_msb;
    head_ready  = sel ? axis_out_1_tready : axis_out_0_tready;
    consume     = head_valid && head_ready;
    state_n     = state;
    route_sel_n = route_sel;
    route_err_n = route_err;
    case (state)
      IDLE: begin
        if (consume && !head_tlast) begin
          state_n     = BUSY;
          route_sel_n = sel;
        end
      end
      BUSY: begin
        if (consume && (head_msb != route_sel)) route_err_n = 1'b1;
        if (consume && head_tlast)              state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      route_sel <= 1'b0;
      route_err <= 1'b0;
    end else begin
      state     <= state_n;
      route_sel <= route_sel_n;
      route_err <= route_err_n;
    end
  end

  assign axis_out_0_tvalid = head_valid && !sel;
  assign axis_out_1_tvalid = head_valid && sel;

  assign axis_out_0_tdata  = head_tdata;
  assign axis_out_0_tkeep  = head_tkeep;
  assign axis_out_0_tid    = head_tid[AXIS_OUT_TID_WIDTH-1:0];
  assign axis_out_0_tdest  = head_tdest;
  assign axis_out_0_tuser  = head_tuser;
  assign axis_out_0_tlast  = head_tlast;

  assign axis_out_1_tdata  = head_tdata;
  assign axis_out_1_tkeep  = head_tkeep;
  assign axis_out_1_tid    = head_tid[AXIS_OUT_TID_WIDTH-1:0];
  assign axis_out_1_tdest  = head_tdest;
  assign axis_out_1_tuser  = head_tuser;
  assign axis_out_1_tlast  = head_tlast;

endmodule
